// File: rtl/kuz_core_arbiter_if.sv
// Requester and response handshake bundle shared by the two block sources,
// the result consumer and the Kuznyechik core arbiter.
interface kuz_core_arbiter_if;
    logic         req0_valid;
    logic [127:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [127:0] req1_data;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_id;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         rsp_ready;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/kuz_core_arbiter.sv
// Round-robin sharing of one Kuznyechik core between two requesters, with
// per-job timeout and ID-tagged responses.
//
// state  | meaning
// S_IDLE | core disabled, waiting to grant a requester
// S_RUN  | core enabled with the latched block, waiting for finish or timeout
// S_RESP | result held on the response port until the consumer takes it
module kuz_core_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    kuz_core_arbiter_if.slave   bus,
    output logic                o_core_enable,
    output logic [127:0]        o_core_input,
    input  logic [127:0]        i_core_output,
    input  logic                i_core_finish,
    output logic                o_busy,
    output logic [15:0]         o_done_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last_grant;
    logic         r_job_id;
    logic [127:0] r_job_data;
    logic [127:0] r_rsp_data;
    logic         r_rsp_err;
    logic [7:0]   r_tmo_cnt;
    logic [15:0]  r_done_count;

    logic         w_gnt_valid;
    logic         w_gnt_id;
    logic         w_accept;
    logic         w_finish;
    logic         w_timeout;
    logic         w_rsp_take;

    // Tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        w_gnt_valid = bus.req0_valid | bus.req1_valid;
        w_gnt_id    = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
        w_accept    = (r_state == S_IDLE) & w_gnt_valid & ~i_rst;
        w_finish    = (r_state == S_RUN) & i_core_finish;
        w_timeout   = (r_state == S_RUN) & (r_tmo_cnt == TMO_LAST);
        w_rsp_take  = (r_state == S_RESP) & bus.rsp_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_finish || w_timeout) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_take) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_job_id     <= 1'b0;
            r_job_data   <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_tmo_cnt    <= '0;
            r_done_count <= '0;
        end else begin
            if (w_accept) begin
                r_job_data   <= w_gnt_id ? bus.req1_data : bus.req0_data;
                r_job_id     <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_tmo_cnt    <= '0;
            end
            if (r_state == S_RUN) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
                // A finish in the timeout cycle still delivers the ciphertext.
                if (w_finish) begin
                    r_rsp_data <= i_core_output;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                end
            end
            if (w_rsp_take) begin
                r_done_count <= r_done_count + 16'd1;
            end
        end
    end

    assign bus.req0_ready = w_accept & ~w_gnt_id;
    assign bus.req1_ready = w_accept & w_gnt_id;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_job_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;

    assign o_core_enable  = (r_state == S_RUN);
    assign o_core_input   = r_job_data;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done_count   = r_done_count;

endmodule

// File: doc/kuz_core_arbiter.md
# kuz_core_arbiter

Round-robin arbiter and sequencer that shares one Kuznyechik encryption core (`shiphrator`) between two requesters. It accepts 128-bit blocks over valid/ready handshakes, drives the core's `enable`/`input_word`, and waits for `finish`. It returns each result tagged with the requester ID, or an error if the core times out. It sits between the protocol-side requesters and the single encryption core; round keys are wired to the core elsewhere and are not touched here.

## Interface
- `TIMEOUT`, 64: maximum cycles in RUN before the job is aborted (range 2..255).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a block.
- `req0_data` in 128: requester 0 plaintext.
- `req0_ready` out 1: requester 0 block accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same for requester 1.
- `rsp_valid` out 1: result available.
- `rsp_id` out 1: requester that owns the result.
- `rsp_data` out 128: ciphertext; zero when `rsp_err`=1.
- `rsp_err` out 1: job aborted by timeout.
- `rsp_ready` in 1: consumer takes the result.
- `core_enable` out 1: to core `enable`.
- `core_input` out 128: to core `input_word`.
- `core_output` in 128: from core `output_word`.
- `core_finish` in 1: from core `finish`.
- `busy` out 1: state is not IDLE.
- `done_count` out 16: completed jobs, errors included; wraps at 0xFFFF→0.

## Operation
States: IDLE, RUN, RESP.

IDLE:
- `core_enable`=0.
- Grant rule: if exactly one `reqN_valid` is high, that requester is granted.
- If both are high, the requester other than `last_grant` is granted.
- `reqN_ready` is combinational: it is 1 only for the granted requester, and only in IDLE.
- On a grant: latch the data into `job_data` and the ID into `job_id`, set `last_grant`, clear the timeout counter, go to RUN.

RUN:
- `core_enable`=1 and `core_input`=`job_data`, both stable for the whole state.
- The timeout counter increments each cycle.
- If `core_finish`=1: capture `core_output` into `rsp_data`, set `rsp_err`=0, go to RESP.
- Else, if the counter reaches `TIMEOUT`-1: set `rsp_data`=0 and `rsp_err`=1, go to RESP.
- If `core_finish` and the timeout occur in the same cycle, finish wins.

RESP:
- `core_enable`=0.
- `rsp_valid`=1; `rsp_id`, `rsp_data` and `rsp_err` are held stable until the handshake.
- On `rsp_ready`=1: increment `done_count`, go to IDLE.
- `reqN_ready` is 0 throughout; requests wait.

General rules:
- `core_enable` is low for at least 2 cycles between jobs (RESP plus IDLE). The core uses this low period to restart.
- `core_finish` is ignored outside RUN.
- `reqN_data` is not required to stay stable after the accept cycle.

Reset:
- State returns to IDLE; an in-flight job is dropped with no response and no count.
- `last_grant`=1, so requester 0 wins the first tie.
- All outputs reset to 0: `req*_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `core_enable`, `core_input`, `busy`, `done_count`.

## Timing
- Accept in cycle T: RUN and `core_enable`=1 start from cycle T+1.
- `core_finish` first sampled high in cycle F: `rsp_valid`=1 from cycle F+1.
- Handshake in cycle H: IDLE in H+1; the next accept can occur in H+1, with its RUN starting at H+2.
- Timeout: `rsp_valid` is asserted exactly `TIMEOUT`+1 cycles after the accept cycle.
- Back-to-back throughput: one job per (core latency + 3) cycles.
- Fairness: when both requesters are continuously valid, grants strictly alternate 0,1,0,1….

## Test plan
- Single job through the real core: req0 sends 1122334455667700ffeeddccbbaa9988 with the standard GOST round keys on the core, `rsp_ready`=1. Required: `rsp_data`=7f679d90bebc24305a468d42b9d4edcd, `rsp_id`=0, `rsp_err`=0, `done_count`=1.
- Contention: both requesters are valid from the first cycle after reset. Required: grants go 0,1,0,1 over 4 jobs; each `reqN_ready` pulses exactly once per grant; `rsp_id` sequence is 0,1,0,1.
- Backpressure: hold `rsp_ready`=0 for 20 cycles after `rsp_valid`. Required: response fields stay stable, `core_enable`=0, both `reqN_ready`=0; the handshake completes on the cycle `rsp_ready` rises.
- Timeout: a stub core never asserts finish, `TIMEOUT`=8, accept in cycle T. Required: `rsp_valid` in cycle T+9 with `rsp_err`=1 and `rsp_data`=0; the next job proceeds normally.
- Finish and timeout coincide: the stub asserts finish on the 8th RUN cycle with `TIMEOUT`=8. Required: `rsp_err`=0 and `rsp_data`=the stub output.
- Reset mid-RUN: assert `rst` for 1 cycle during RUN. Required: the next cycle is IDLE, with `core_enable`=0, `rsp_valid`=0 and `done_count`=0; no response is produced for the dropped job; with both requesters valid, the first grant after reset goes to req0.
